// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the multi-cycle Hack CPU:
//   - state_e      : control FSM states (FETCH, EXEC, MEM_RD, MEM_WR)
//   - field indices: bit positions of the C-instruction fields (low 13 bits)
//   - jump_taken() : Hack jump condition from j1..j3 and the ALU flags
// -----------------------------------------------------------------------------
package hack_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      EXEC   = 2'd1,
      MEM_RD = 2'd2,
      MEM_WR = 2'd3
   } state_e;

   // C-instruction fields always live in the low 13 bits, whatever WIDTH is.
   localparam int A_BIT = 12;  // a: y operand is M instead of A
   localparam int C_HI  = 11;  // c1..c6 = inst[11:6] (zx,nx,zy,ny,f,no)
   localparam int D_A   = 5;   // d1: write A
   localparam int D_D   = 4;   // d2: write D
   localparam int D_M   = 3;   // d3: write M
   localparam int J_LT  = 2;   // j1: jump if out < 0
   localparam int J_EQ  = 1;   // j2: jump if out == 0
   localparam int J_GT  = 0;   // j3: jump if out > 0

   function automatic logic jump_taken(input logic [2:0] j,
                                       input logic       zr,
                                       input logic       ng);
      return (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_alu_p.sv
// -----------------------------------------------------------------------------
// hack_alu_p
// Combinational Hack ALU at a parametrised width.
// Ports:
//   x_i    [WIDTH-1:0]  x operand (D register)
//   y_i    [WIDTH-1:0]  y operand (A register or M read data)
//   ctrl_i [5:0]        {zx, nx, zy, ny, f, no}
//   out_o  [WIDTH-1:0]  result
//   zr_o                result is zero
//   ng_o                result is negative (MSB set)
// -----------------------------------------------------------------------------
module hack_alu_p #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [5:0]       ctrl_i,
   output logic [WIDTH-1:0] out_o,
   output logic             zr_o,
   output logic             ng_o
);

   logic zx, nx, zy, ny, f, no;
   logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_out;

   assign {zx, nx, zy, ny, f, no} = ctrl_i;

   assign x_z   = zx ? '0 : x_i;
   assign x_n   = nx ? ~x_z : x_z;
   assign y_z   = zy ? '0 : y_i;
   assign y_n   = ny ? ~y_z : y_z;
   assign f_out = f ? (x_n + y_n) : (x_n & y_n);
   assign out_o = no ? ~f_out : f_out;

   assign zr_o = (out_o == '0);
   assign ng_o = out_o[WIDTH-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// -----------------------------------------------------------------------------
// hack_cpu_mc
// Multi-cycle Hack CPU with req/ready instruction and data memory ports.
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   imem_req/addr              fetch request, address (= pc)
//   imem_ready/rdata           fetch completion and instruction word
//   dmem_req/we/addr/wdata     data access request, direction, address, data
//   dmem_ready/rdata           access completion and read data
//   pc                         current program counter
//   retire                     one-cycle pulse when an instruction completes
//
// Handshake: a requester raises req together with stable addr/we/wdata and
// holds all of them unchanged until the cycle in which ready is seen high;
// that cycle completes the transfer. req never drops before ready (only a
// reset may abandon a request). ready while req is low is ignored.
//
// Memory-side outputs are registered and computed from the next state, so
// they come out low during reset and the first fetch appears in the cycle
// after reset is released. retire is combinational so it marks the exact
// cycle in which an instruction completes.
// -----------------------------------------------------------------------------
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [WIDTH-1:0]  imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [WIDTH-1:0]  dmem_wdata,
   input  logic              dmem_ready,
   input  logic [WIDTH-1:0]  dmem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              retire
);

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   ir_q, ir_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               imem_req_q, imem_req_d;
   logic               dmem_req_q, dmem_req_d;
   logic               dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0]  dmem_addr_q, dmem_addr_d;
   logic [WIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic               retire_c;
   logic               commit;

   logic               is_c;
   logic               a_sel;
   logic [WIDTH-1:0]   alu_y;
   logic [WIDTH-1:0]   alu_out;
   logic               alu_zr, alu_ng;
   logic               jump;
   logic [ADDR_W-1:0]  pc_inc;

   assign is_c   = ir_q[WIDTH-1];
   assign a_sel  = ir_q[A_BIT];
   // In MEM_RD the y operand is the read data; a_q is only selected when a=0.
   assign alu_y  = a_sel ? dmem_rdata : a_q;
   assign jump   = jump_taken(ir_q[J_LT:J_GT], alu_zr, alu_ng);
   assign pc_inc = pc_q + PC_ONE;  // wraps naturally at 2^ADDR_W

   hack_alu_p #(.WIDTH(WIDTH)) u_alu (
      .x_i    (d_q),
      .y_i    (alu_y),
      .ctrl_i (ir_q[C_HI -: 6]),
      .out_o  (alu_out),
      .zr_o   (alu_zr),
      .ng_o   (alu_ng)
   );

   // Next-state, register updates and retire.
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      a_d      = a_q;
      d_d      = d_q;
      pc_d     = pc_q;
      retire_c = 1'b0;
      commit   = 1'b0;

      case (state_q)
         FETCH: begin
            if (imem_req_q && imem_ready) begin
               ir_d    = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (!is_c) begin
               a_d      = {1'b0, ir_q[WIDTH-2:0]};
               pc_d     = pc_inc;
               retire_c = 1'b1;
               state_d  = FETCH;
            end else if (a_sel) begin
               state_d = MEM_RD;
            end else begin
               commit = 1'b1;
            end
         end
         MEM_RD: begin
            if (dmem_req_q && dmem_ready) commit = 1'b1;
         end
         MEM_WR: begin
            if (dmem_req_q && dmem_ready) begin
               retire_c = 1'b1;
               state_d  = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      // C-instruction completion: a_q is still the pre-instruction A here,
      // so the jump target and the M address both see the old value.
      if (commit) begin
         if (ir_q[D_A]) a_d = alu_out;
         if (ir_q[D_D]) d_d = alu_out;
         pc_d = jump ? a_q[ADDR_W-1:0] : pc_inc;
         if (ir_q[D_M]) begin
            state_d = MEM_WR;
         end else begin
            retire_c = 1'b1;
            state_d  = FETCH;
         end
      end
   end

   // Memory-side outputs, derived from the state being entered.
   always_comb begin
      imem_req_d   = (state_d == FETCH);
      dmem_req_d   = (state_d == MEM_RD) || (state_d == MEM_WR);
      dmem_we_d    = (state_d == MEM_WR);
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      // Address/data are captured only on entry to a data state and then
      // held, which keeps them stable for the whole request.
      if (dmem_req_d && (state_d != state_q)) dmem_addr_d = a_q[ADDR_W-1:0];
      if ((state_d == MEM_WR) && (state_q != MEM_WR)) dmem_wdata_d = alu_out;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= FETCH;
         ir_q         <= '0;
         a_q          <= '0;
         d_q          <= '0;
         pc_q         <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         a_q          <= a_d;
         d_q          <= d_d;
         pc_q         <= pc_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign pc         = pc_q;
   assign retire     = retire_c;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// -----------------------------------------------------------------------------
// tb_hack_cpu_mc
// Directed bench for hack_cpu_mc: a 16-bit instance drives most scenarios,
// a 32-bit instance covers the wide-word decode.
// -----------------------------------------------------------------------------
module tb_hack_cpu_mc;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int checks = 0;
   int failures = 0;

   // ---------------- 16-bit DUT ----------------
   logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire;
   logic [14:0] imem_addr, dmem_addr, pc;
   logic [15:0] imem_rdata, dmem_wdata, dmem_rdata;

   hack_cpu_mc #(.WIDTH(16), .ADDR_W(15)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ready (dmem_ready),
      .dmem_rdata (dmem_rdata),
      .pc         (pc),
      .retire     (retire)
   );

   // ---------------- 32-bit DUT ----------------
   logic        imem_req32, imem_ready32, dmem_req32, dmem_we32, dmem_ready32, retire32;
   logic [14:0] imem_addr32, dmem_addr32, pc32;
   logic [31:0] imem_rdata32, dmem_wdata32, dmem_rdata32;

   hack_cpu_mc #(.WIDTH(32), .ADDR_W(15)) u_dut32 (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req32),
      .imem_addr  (imem_addr32),
      .imem_ready (imem_ready32),
      .imem_rdata (imem_rdata32),
      .dmem_req   (dmem_req32),
      .dmem_we    (dmem_we32),
      .dmem_addr  (dmem_addr32),
      .dmem_wdata (dmem_wdata32),
      .dmem_ready (dmem_ready32),
      .dmem_rdata (dmem_rdata32),
      .pc         (pc32),
      .retire     (retire32)
   );

   // Retire monitor for the 16-bit DUT, sampled mid-cycle.
   int ret_cnt = 0;
   int last_ret_cyc = -1;
   always @(negedge clk) begin
      if (retire === 1'b1) begin
         ret_cnt      <= ret_cnt + 1;
         last_ret_cyc <= cyc_cnt;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for one cycle (zero-wait fetch).
   task automatic fetch(input logic [15:0] inst);
      imem_ready = 1'b1;
      imem_rdata = inst;
      step();
      imem_ready = 1'b0;
      imem_rdata = 16'hDEAD;
   endtask

   // Fetch plus the EXEC cycle of a 2-cycle instruction.
   task automatic exec_simple(input logic [15:0] inst);
      fetch(inst);
      step();
   endtask

   task automatic mem_ack(input logic [15:0] rdata);
      dmem_ready = 1'b1;
      dmem_rdata = rdata;
      step();
      dmem_ready = 1'b0;
      dmem_rdata = 16'hBEEF;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) step();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL rst_dmem_req: got %b want 0", dmem_req); end
      checks++; if (pc !== 15'd0) begin failures++; $display("FAIL rst_pc: got %h want 0", pc); end
      checks++; if (retire !== 1'b0) begin failures++; $display("FAIL rst_retire: got %b want 0", retire); end
      checks++; if ({dmem_we, dmem_addr, dmem_wdata} !== 32'd0) begin failures++; $display("FAIL rst_dmem_outs: got we=%b addr=%h wdata=%h want 0", dmem_we, dmem_addr, dmem_wdata); end
      reset = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 15'd0) begin failures++; $display("FAIL rst_first_fetch: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
   endtask

   task automatic test_program();
      int c0, r0;
      c0 = cyc_cnt;
      r0 = ret_cnt;
      exec_simple(16'h0005);          // @5
      checks++; if (last_ret_cyc !== c0 + 1) begin failures++; $display("FAIL prog_retire1: got cycle %0d want %0d", last_ret_cyc, c0 + 1); end
      checks++; if (imem_addr !== 15'd1 || imem_req !== 1'b1) begin failures++; $display("FAIL prog_fetch2: got req=%b addr=%h want 1/1", imem_req, imem_addr); end
      exec_simple(16'hEC10);          // D=A
      checks++; if (last_ret_cyc !== c0 + 3 || ret_cnt !== r0 + 2) begin failures++; $display("FAIL prog_retire2: got cycle %0d cnt %0d want %0d/%0d", last_ret_cyc, ret_cnt - r0, c0 + 3, 2); end
      checks++; if (pc !== 15'd2) begin failures++; $display("FAIL prog_pc: got %h want 2", pc); end
      fetch(16'hE308);                // M=D
      step();
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 15'd5 || dmem_wdata !== 16'd5) begin failures++; $display("FAIL prog_d_value: got req=%b we=%b addr=%h wdata=%h want 1/1/5/5", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      mem_ack(16'h0);
   endtask

   task automatic test_write_wait();
      int r0, ack_cyc;
      logic bad;
      exec_simple(16'd100);           // @100
      fetch(16'hE7C8);                // M=D+1, D=5
      step();
      r0 = ret_cnt;
      bad = 1'b0;
      ack_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 15'd100 || dmem_wdata !== 16'd6) bad = 1'b1;
         if (i == 3) begin
            dmem_ready = 1'b1;
            ack_cyc = cyc_cnt;
         end
         step();
      end
      dmem_ready = 1'b0;
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL wr_hold: got unstable/incorrect write fields want req=1 we=1 addr=100 wdata=6 for 4 cycles"); end
      checks++; if (ret_cnt !== r0 + 1 || last_ret_cyc !== ack_cyc) begin failures++; $display("FAIL wr_retire: got cnt %0d at cycle %0d want 1 at %0d", ret_cnt - r0, last_ret_cyc, ack_cyc); end
      checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b1 || pc !== 15'd5) begin failures++; $display("FAIL wr_after: got dreq=%b ireq=%b pc=%h want 0/1/5", dmem_req, imem_req, pc); end
   endtask

   task automatic test_read_wait();
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 2; i++) begin  // fetch wait states
         if (imem_req !== 1'b1 || imem_addr !== 15'd5) bad = 1'b1;
         imem_ready = 1'b0;
         step();
      end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL fetch_hold: got req/addr not held want req=1 addr=5"); end
      fetch(16'd7);
      step();
      fetch(16'hFC10);                // D=M
      step();
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 15'd7) begin failures++; $display("FAIL rd_req: got req=%b we=%b addr=%h want 1/0/7", dmem_req, dmem_we, dmem_addr); end
      step();
      step();
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 15'd7) begin failures++; $display("FAIL rd_hold: got req=%b addr=%h want 1/7", dmem_req, dmem_addr); end
      mem_ack(16'h1234);
      checks++; if (pc !== 15'd7 || dmem_req !== 1'b0) begin failures++; $display("FAIL rd_pc: got pc=%h dreq=%b want 7/0", pc, dmem_req); end
      exec_simple(16'd9);
      fetch(16'hE308);                // M=D
      step();
      checks++; if (dmem_addr !== 15'd9 || dmem_wdata !== 16'h1234 || dmem_we !== 1'b1) begin failures++; $display("FAIL rd_d_value: got addr=%h wdata=%h we=%b want 9/1234/1", dmem_addr, dmem_wdata, dmem_we); end
      mem_ack(16'h0);
   endtask

   task automatic test_rmw();
      int c0, r0;
      exec_simple(16'd7);
      c0 = cyc_cnt;
      fetch(16'hFDE8);                // AM=M+1
      step();
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 15'd7) begin failures++; $display("FAIL rmw_read: got req=%b we=%b addr=%h want 1/0/7", dmem_req, dmem_we, dmem_addr); end
      r0 = ret_cnt;
      mem_ack(16'd9);
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 15'd7 || dmem_wdata !== 16'd10) begin failures++; $display("FAIL rmw_write: got req=%b we=%b addr=%h wdata=%h want 1/1/7/a", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      checks++; if (ret_cnt !== r0) begin failures++; $display("FAIL rmw_early_retire: got %0d retires want 0", ret_cnt - r0); end
      mem_ack(16'h0);
      checks++; if (last_ret_cyc !== c0 + 3 || pc !== 15'd11) begin failures++; $display("FAIL rmw_latency: got cycle %0d pc=%h want %0d/b", last_ret_cyc, pc, c0 + 3); end
      fetch(16'hE308);                // M=D, A should be 10
      step();
      checks++; if (dmem_addr !== 15'd10) begin failures++; $display("FAIL rmw_new_a: got addr=%h want a", dmem_addr); end
      mem_ack(16'h0);
   endtask

   task automatic test_jumps();
      exec_simple(16'hEA90);          // D=0
      exec_simple(16'd42);
      exec_simple(16'hE302);          // D;JEQ taken
      checks++; if (pc !== 15'd42 || imem_addr !== 15'd42) begin failures++; $display("FAIL jeq: got pc=%h addr=%h want 2a", pc, imem_addr); end
      exec_simple(16'd42);
      exec_simple(16'hE301);          // D;JGT not taken
      checks++; if (pc !== 15'd44) begin failures++; $display("FAIL jgt: got pc=%h want 2c", pc); end
      exec_simple(16'hEA87);          // 0;JMP
      checks++; if (pc !== 15'd42) begin failures++; $display("FAIL jmp: got pc=%h want 2a", pc); end
      exec_simple(16'hEE90);          // D=-1
      exec_simple(16'd42);
      exec_simple(16'hE304);          // D;JLT taken
      checks++; if (pc !== 15'd42) begin failures++; $display("FAIL jlt: got pc=%h want 2a", pc); end
      exec_simple(16'hE327);          // A=D;JMP, target is old A
      checks++; if (pc !== 15'd42) begin failures++; $display("FAIL ajmp_pc: got pc=%h want 2a", pc); end
      fetch(16'hE308);                // M=D, A is now 0xFFFF
      step();
      checks++; if (dmem_addr !== 15'h7FFF || dmem_wdata !== 16'hFFFF) begin failures++; $display("FAIL ajmp_a: got addr=%h wdata=%h want 7fff/ffff", dmem_addr, dmem_wdata); end
      mem_ack(16'h0);
   endtask

   task automatic test_pc_wrap();
      exec_simple(16'h7FFF);
      exec_simple(16'hEA87);          // 0;JMP to 0x7FFF
      checks++; if (pc !== 15'h7FFF || imem_addr !== 15'h7FFF) begin failures++; $display("FAIL wrap_top: got pc=%h addr=%h want 7fff", pc, imem_addr); end
      exec_simple(16'hEC10);          // D=A, no jump
      checks++; if (pc !== 15'd0) begin failures++; $display("FAIL wrap_zero: got pc=%h want 0", pc); end
   endtask

   task automatic test_reset_mid_write();
      exec_simple(16'd100);
      fetch(16'hE308);                // M=D, sits in MEM_WR without ready
      step();
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL mid_pre: got req=%b we=%b want 1/1", dmem_req, dmem_we); end
      reset = 1'b0;
      step();
      step();
      checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || pc !== 15'd0 || retire !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL mid_reset: got dreq=%b we=%b pc=%h ret=%b ireq=%b want all 0", dmem_req, dmem_we, pc, retire, imem_req); end
      reset = 1'b1;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 15'd0 || dmem_req !== 1'b0) begin failures++; $display("FAIL mid_release: got ireq=%b addr=%h dreq=%b want 1/0/0", imem_req, imem_addr, dmem_req); end
      fetch(16'hE308);                // M=D: A and D must both be 0
      step();
      checks++; if (dmem_addr !== 15'd0 || dmem_wdata !== 16'd0) begin failures++; $display("FAIL mid_regs: got addr=%h wdata=%h want 0/0", dmem_addr, dmem_wdata); end
      mem_ack(16'h0);
   endtask

   task automatic test_width32();
      checks++; if (imem_req32 !== 1'b1 || imem_addr32 !== 15'd0) begin failures++; $display("FAIL w32_fetch0: got req=%b addr=%h want 1/0", imem_req32, imem_addr32); end
      imem_ready32 = 1'b1; imem_rdata32 = 32'hFFFF_FFFF;
      step();
      imem_ready32 = 1'b0; imem_rdata32 = '0;
      step();
      // Low 13 bits 0x1FFF: a=1, out=1, d=AMD, JMP; must go to a read of A=0.
      checks++; if (dmem_req32 !== 1'b1 || dmem_we32 !== 1'b0 || dmem_addr32 !== 15'd0 || imem_req32 !== 1'b0) begin failures++; $display("FAIL w32_c_decode: got dreq=%b we=%b addr=%h ireq=%b want 1/0/0/0", dmem_req32, dmem_we32, dmem_addr32, imem_req32); end
      dmem_ready32 = 1'b1; dmem_rdata32 = 32'd5;
      step();
      dmem_ready32 = 1'b0;
      checks++; if (dmem_we32 !== 1'b1 || dmem_addr32 !== 15'd0 || dmem_wdata32 !== 32'd1) begin failures++; $display("FAIL w32_c_write: got we=%b addr=%h wdata=%h want 1/0/1", dmem_we32, dmem_addr32, dmem_wdata32); end
      dmem_ready32 = 1'b1;
      step();
      dmem_ready32 = 1'b0;
      checks++; if (pc32 !== 15'd0 || imem_req32 !== 1'b1) begin failures++; $display("FAIL w32_c_jump: got pc=%h ireq=%b want 0/1", pc32, imem_req32); end
      imem_ready32 = 1'b1; imem_rdata32 = 32'h7FFF_FFFF;
      step();
      imem_ready32 = 1'b0;
      step();
      imem_ready32 = 1'b1; imem_rdata32 = 32'hFFFF_E308;   // M=D
      step();
      imem_ready32 = 1'b0;
      step();
      checks++; if (dmem_req32 !== 1'b1 || dmem_we32 !== 1'b1 || dmem_addr32 !== 15'h7FFF || dmem_wdata32 !== 32'd1) begin failures++; $display("FAIL w32_a_load: got req=%b we=%b addr=%h wdata=%h want 1/1/7fff/1", dmem_req32, dmem_we32, dmem_addr32, dmem_wdata32); end
      dmem_ready32 = 1'b1;
      step();
      dmem_ready32 = 1'b0;
      checks++; if (pc32 !== 15'd2) begin failures++; $display("FAIL w32_pc: got pc=%h want 2", pc32); end
   endtask

   initial begin
      imem_ready = 1'b0;   imem_rdata = '0;
      dmem_ready = 1'b0;   dmem_rdata = '0;
      imem_ready32 = 1'b0; imem_rdata32 = '0;
      dmem_ready32 = 1'b0; dmem_rdata32 = '0;

      test_reset();
      test_program();
      test_write_wait();
      test_read_wait();
      test_rmw();
      test_jumps();
      test_pc_wrap();
      test_reset_mid_write();
      test_width32();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hack_cpu_mc.md
Name: hack_cpu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle Hack CPU. It executes the same A/C instruction set.
- Width is generalised, and instruction and data memory are accessed through req/ready handshakes, so variable-latency memories (wait states) are supported.
- Sits between the program ROM / data RAM interconnect and the system top; exposes a per-instruction retire pulse for tracing and test.

Parameters:
- WIDTH, 16, data/register/instruction width (>=16).
- ADDR_W, 15, address width for PC, imem_addr and dmem_addr (<= WIDTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset; synchronous, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  WIDTH  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  WIDTH  write data.
- dmem_ready  in  1  access complete; dmem_rdata valid this cycle for reads.
- dmem_rdata  in  WIDTH  read data.
- pc  out  ADDR_W  current program counter.
- retire  out  1  one-cycle pulse when an instruction completes.

Behaviour:
- Decode: inst[WIDTH-1]=0 is an A-instruction, which loads A with inst, MSB forced to 0.
- C-instruction fields are always at the low 13 bits: a=inst[12], c1..c6=inst[11:6], d1..d3=inst[5:3] (A,D,M), j1..j3=inst[2:0] (LT,EQ,GT).
- ALU: Hack semantics (zx,nx,zy,ny,f,no) at WIDTH bits; x=D, y=(a ? M : A). zr = (out==0); ng = out[WIDTH-1].
- Jump condition: (j1&ng) | (j2&zr) | (j3&~ng&~zr).
- All M accesses use the A value from before the instruction. The jump target is also the pre-instruction A, truncated to ADDR_W.
- PC increment wraps: 2^ADDR_W-1 -> 0.
- FSM states: FETCH, EXEC, MEM_RD, MEM_WR.
- FETCH: imem_req=1, imem_addr=pc. Hold until imem_ready, then latch IR -> EXEC.
- EXEC, A-instruction: A<=IR, pc<=pc+1, retire=1 -> FETCH.
- EXEC, C-instruction with a=1: -> MEM_RD.
- EXEC, C-instruction with a=0: compute; write A if d1, D if d2; pc <= jump ? A_old : pc+1.
  - d3=1: latch waddr=A_old, wdata=aluOut -> MEM_WR.
  - d3=0: retire -> FETCH.
- MEM_RD: dmem_req=1, we=0, addr=A. On dmem_ready, compute with y=dmem_rdata and update exactly as EXEC a=0, including the d3 branch.
- MEM_WR: dmem_req=1, we=1, addr=waddr, wdata=wdata. On dmem_ready: retire -> FETCH.
- Handshake rules:
  - Once req is asserted, addr/we/wdata are held stable until the ready cycle.
  - req is never deasserted before ready, except by reset.
  - ready while req=0 is ignored.
- Latency (zero wait states):
  - A-instruction: 2 cycles.
  - C without M: 2 cycles.
  - M read: 3 cycles.
  - M write: 3 cycles.
  - Read-modify-write: 4 cycles.
  - Each wait cycle adds 1.
- Reset (reset=0 at a clk edge):
  - Next state: FETCH; pc=0, A=0, D=0, IR=0.
  - All outputs are registered-low during reset: imem_req=0, dmem_req=0, dmem_we=0, retire=0, addrs/wdata=0.
  - Reset overrides any in-flight transaction; the abandoned request is dropped and memories must tolerate that.
  - First fetch (addr 0) is asserted in the cycle after reset returns to 1.
- Simultaneous jump and A-write (e.g. A=D;JMP): jump uses A_old; A gets the new value.
- D write and M write in the same instruction: both use the same aluOut.

Decomposition:
- hack_pkg: state enum; field index constants (A_BIT=12, C_HI=11, D_A=5, D_D=4, D_M=3, J_LT=2, J_EQ=1, J_GT=0).
- Sub-module hack_alu_p #(WIDTH): combinational ALU producing out, zr, ng.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-MEM_WR -> dmem_req=0, pc=0, retire=0. Release -> imem_req=1, imem_addr=0 next cycle.
- 0-wait program @5 (0x0005), D=A (0xEC10) -> D=5; retire pulses at cycles 2 and 4; pc=2.
- A=100, D=5, M=D+1 (0xE7C8) with dmem_ready delayed 3 cycles -> dmem_req=1, we=1, addr=100, wdata=6 held stable for 4 cycles; one retire on the ready cycle.
- D=M (0xFC10), A=7, rdata=0x1234 after 2 waits -> dmem_we=0, D=0x1234, pc+1.
- AM=M+1 (0xFDE8), A=7, mem[7]=9 -> write addr=7, data=10; afterwards A=10.
- Jumps, with A=42:
  - D=0, D;JEQ (0xE302) -> pc=42.
  - D=0, D;JGT (0xE301) -> pc+1.
  - 0;JMP (0xEA87) -> pc=42.
- ADDR_W=15 with pc=0x7FFF and a non-jump instruction -> pc wraps to 0.
- WIDTH=32: A-instruction 0xFFFF_FFFF is treated as a C-instruction; A-instruction 0x7FFF_FFFF -> A=0x7FFF_FFFF, dmem_addr=0x7FFF.
